// File: rtl/cp0_exception.sv
// MIPS CP0 exception back end: prioritises M-stage faults and interrupts,
// owns Status/Cause/EPC/BadVAddr/Count/Compare and drives the pipeline redirect.
`timescale 1ns/1ps
module cp0_exception #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic        cp0writeM,
    input  logic [4:0]  waddrM,
    input  logic [31:0] wdataM,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [31:0] pcM,
    input  logic        in_delayslotM,
    input  logic        invalidM,
    input  logic        syscallM,
    input  logic        breakM,
    input  logic        eretM,
    input  logic        overflowM,
    input  logic        adel_fetchM,
    input  logic        adel_dataM,
    input  logic        ades_dataM,
    input  logic [31:0] bad_addrM,
    input  logic [5:0]  int_i,
    output logic        flush,
    output logic [31:0] newpc,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    logic [7:0]  im;
    logic        exl, ie;
    logic        bd, ti;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc, badvaddr, count, compare;
    logic        toggle;

    logic [31:0] status, cause;
    logic        int_pend, exc, eret_take, wr_en, wr_count, wr_compare;
    logic [4:0]  code;
    logic        bad_upd;
    logic [31:0] bad_val;
    logic [31:0] count_next;

    assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause  = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};

    assign int_pend = ie & ~exl & (|({ip_hw, ip_sw} & im));

    always_comb begin
        exc     = 1'b1;
        code    = 5'd0;
        bad_upd = 1'b0;
        bad_val = pcM;
        if (int_pend)          code = 5'd0;
        else if (adel_fetchM) begin
            code    = 5'd4;
            bad_upd = 1'b1;
        end
        else if (invalidM)     code = 5'd10;
        else if (overflowM)    code = 5'd12;
        else if (syscallM)     code = 5'd8;
        else if (breakM)       code = 5'd9;
        else if (adel_dataM) begin
            code    = 5'd4;
            bad_upd = 1'b1;
            bad_val = bad_addrM;
        end
        else if (ades_dataM) begin
            code    = 5'd5;
            bad_upd = 1'b1;
            bad_val = bad_addrM;
        end
        else                   exc = 1'b0;
    end

    assign eret_take  = eretM & ~exc;
    // rst gating lets flush fall as soon as reset asserts, not at the next edge
    assign flush      = rst & ~stallM & (exc | eretM);
    assign newpc      = exc ? EXC_VECTOR : epc;
    assign wr_en      = cp0writeM & ~stallM & ~exc & ~eretM;
    assign wr_count   = wr_en & (waddrM == REG_COUNT);
    assign wr_compare = wr_en & (waddrM == REG_COMPARE);
    assign count_next = wr_count ? wdataM : count + {31'b0, toggle};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im       <= 8'b0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ti       <= 1'b0;
            ip_hw    <= 6'b0;
            ip_sw    <= 2'b0;
            exc_code <= 5'b0;
            epc      <= 32'b0;
            badvaddr <= 32'b0;
            count    <= 32'b0;
            compare  <= 32'b0;
            toggle   <= 1'b0;
        end else begin
            count  <= count_next;
            toggle <= wr_count ? 1'b0 : ~toggle;
            ip_hw  <= {int_i[5] | ti, int_i[4:0]};
            if (wr_compare)                 ti <= 1'b0;
            else if (count_next == compare) ti <= 1'b1;
            if (!stallM) begin
                if (exc) begin
                    exc_code <= code;
                    bd       <= in_delayslotM;
                    exl      <= 1'b1;
                    if (!exl) epc <= in_delayslotM ? pcM - 32'd4 : pcM;
                    if (bad_upd) badvaddr <= bad_val;
                end else if (eret_take) begin
                    exl <= 1'b0;
                end else if (wr_en) begin
                    case (waddrM)
                        REG_COMPARE: compare <= wdataM;
                        REG_STATUS: begin
                            im  <= wdataM[15:8];
                            exl <= wdataM[1];
                            ie  <= wdataM[0];
                        end
                        REG_CAUSE:   ip_sw <= wdataM[9:8];
                        REG_EPC:     epc   <= wdataM;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        case (raddr)
            REG_BADVADDR: rdata = badvaddr;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = status;
            REG_CAUSE:    rdata = cause;
            REG_EPC:      rdata = epc;
            REG_PRID:     rdata = PRID_VALUE;
            default:      rdata = 32'b0;
        endcase
    end

    assign status_o  = status;
    assign cause_o   = cause;
    assign epc_o     = epc;
    assign timer_int = ti;
endmodule

// File: tb/tb_cp0_exception.sv
// Bench for cp0_exception: directed table, hand-written corner sequences and
// random cycles, all compared against a behavioural CP0 model.
`timescale 1ns/1ps
module tb_cp0_exception;
    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [31:0] PRID = 32'h0000_4220;
    localparam int CODES [8] = '{0, 4, 10, 12, 8, 9, 4, 5};
    localparam int OP_INV = 1, OP_SYS = 2, OP_BRK = 4, OP_ERET = 8, OP_OV = 16,
                   OP_ADELF = 32, OP_ADELD = 64, OP_ADES = 128, OP_WR = 256;

    logic clk = 1'b0;
    logic rst;
    logic stallM, cp0writeM, in_delayslotM;
    logic [4:0] waddrM, raddr;
    logic [31:0] wdataM, rdata, pcM, bad_addrM, newpc, status_o, cause_o, epc_o;
    logic invalidM, syscallM, breakM, eretM, overflowM, adel_fetchM, adel_dataM, ades_dataM;
    logic [5:0] int_i;
    logic flush, timer_int;

    cp0_exception dut (
        .clk(clk), .rst(rst), .stallM(stallM), .cp0writeM(cp0writeM), .waddrM(waddrM),
        .wdataM(wdataM), .raddr(raddr), .rdata(rdata), .pcM(pcM), .in_delayslotM(in_delayslotM),
        .invalidM(invalidM), .syscallM(syscallM), .breakM(breakM), .eretM(eretM),
        .overflowM(overflowM), .adel_fetchM(adel_fetchM), .adel_dataM(adel_dataM),
        .ades_dataM(ades_dataM), .bad_addrM(bad_addrM), .int_i(int_i), .flush(flush),
        .newpc(newpc), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic stall, wr;
        logic [4:0] waddr;
        logic [31:0] wdata;
        logic [4:0] raddr;
        logic [31:0] pc;
        logic ds, inv, sys, brk, eret, ov, adelf, adeld, ades;
        logic [31:0] bad;
        logic [5:0] intr;
    } in_t;

    typedef struct {
        int op;
        logic [31:0] data;
        logic [31:0] pc;
        logic ds;
        logic stall;
        logic [4:0] waddr;
        logic [4:0] raddr;
        logic exp_flush;
        logic [31:0] exp_newpc;
        logic [31:0] exp_rdata;
    } row_t;

    int n_tests = 0;
    int n_fail = 0;

    // behavioural model state; Count is base plus half the edges seen since base was set
    logic [31:0] m_status, m_epc, m_bad, m_compare, m_base;
    int unsigned m_ticks;
    logic m_bd, m_ti;
    logic [4:0] m_code;
    logic [5:0] m_iphw;
    logic [1:0] m_ipsw;

    logic last_flush, last_ti;
    logic [31:0] last_rdata;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_epc = 0; m_bad = 0; m_compare = 0; m_base = 0; m_ticks = 0;
        m_bd = 0; m_ti = 0; m_code = 0; m_iphw = 0; m_ipsw = 0;
    endtask

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks / 2);
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'b0, m_iphw, m_ipsw, 1'b0, m_code, 2'b0};
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a);
        case (a)
            5'd8:  return m_bad;
            5'd9:  return m_count();
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause();
            5'd14: return m_epc;
            5'd15: return PRID;
            default: return 32'b0;
        endcase
    endfunction

    function automatic int m_winner(in_t v);
        bit f [8];
        logic [31:0] c;
        c = m_cause();
        f[0] = m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'b0);
        f[1] = v.adelf; f[2] = v.inv; f[3] = v.ov; f[4] = v.sys;
        f[5] = v.brk; f[6] = v.adeld; f[7] = v.ades;
        for (int i = 0; i < 8; i++) if (f[i]) return i;
        return -1;
    endfunction

    task automatic model_step(in_t v);
        int win;
        logic ti_old, wrote_count, wrote_cmp;
        ti_old = m_ti;
        win = m_winner(v);
        wrote_count = !v.stall && win < 0 && !v.eret && v.wr && v.waddr == 5'd9;
        wrote_cmp   = !v.stall && win < 0 && !v.eret && v.wr && v.waddr == 5'd11;
        if (!v.stall) begin
            if (win >= 0) begin
                m_code = 5'(CODES[win]);
                m_bd = v.ds;
                if (!m_status[1]) m_epc = v.ds ? v.pc - 32'd4 : v.pc;
                m_status[1] = 1'b1;
                if (win == 1) m_bad = v.pc;
                else if (win == 6 || win == 7) m_bad = v.bad;
            end else if (v.eret) begin
                m_status[1] = 1'b0;
            end else if (v.wr) begin
                case (v.waddr)
                    5'd11: m_compare = v.wdata;
                    5'd12: m_status = 32'h0040_0000 | (v.wdata & 32'h0000_FF03);
                    5'd13: m_ipsw = v.wdata[9:8];
                    5'd14: m_epc = v.wdata;
                    default: ;
                endcase
            end
        end
        if (wrote_count) begin
            m_base = v.wdata;
            m_ticks = 0;
        end else begin
            m_ticks++;
        end
        if (wrote_cmp) m_ti = 1'b0;
        else if (m_count() == m_compare) m_ti = 1'b1;
        m_iphw = {v.intr[5] | ti_old, v.intr[4:0]};
    endtask

    function automatic in_t idle_in(logic [4:0] ra);
        in_t v;
        v.stall = 0; v.wr = 0; v.waddr = 0; v.wdata = 0; v.raddr = ra; v.pc = 32'h8000_0000;
        v.ds = 0; v.inv = 0; v.sys = 0; v.brk = 0; v.eret = 0; v.ov = 0;
        v.adelf = 0; v.adeld = 0; v.ades = 0; v.bad = 0; v.intr = 0;
        return v;
    endfunction

    function automatic in_t wr_in(logic [4:0] a, logic [31:0] d, logic [4:0] ra);
        in_t v = idle_in(ra);
        v.wr = 1; v.waddr = a; v.wdata = d;
        return v;
    endfunction

    function automatic in_t row_in(row_t r);
        in_t v = idle_in(r.raddr);
        v.stall = r.stall; v.pc = r.pc; v.ds = r.ds; v.waddr = r.waddr;
        v.wdata = r.data; v.bad = r.data;
        v.wr = (r.op & OP_WR) != 0;     v.inv = (r.op & OP_INV) != 0;
        v.sys = (r.op & OP_SYS) != 0;   v.brk = (r.op & OP_BRK) != 0;
        v.eret = (r.op & OP_ERET) != 0; v.ov = (r.op & OP_OV) != 0;
        v.adelf = (r.op & OP_ADELF) != 0; v.adeld = (r.op & OP_ADELD) != 0;
        v.ades = (r.op & OP_ADES) != 0;
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v = idle_in(5'($urandom_range(7, 16)));
        int sel;
        v.stall = ($urandom_range(0, 7) == 0);
        v.pc = 32'($urandom) & ~32'd3;
        v.ds = 1'($urandom_range(0, 1));
        v.inv = ($urandom_range(0, 19) == 0);  v.sys = ($urandom_range(0, 19) == 0);
        v.brk = ($urandom_range(0, 19) == 0);  v.ov = ($urandom_range(0, 19) == 0);
        v.eret = ($urandom_range(0, 11) == 0); v.adelf = ($urandom_range(0, 24) == 0);
        v.adeld = ($urandom_range(0, 19) == 0); v.ades = ($urandom_range(0, 19) == 0);
        v.bad = 32'($urandom);
        v.intr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
        v.wr = ($urandom_range(0, 2) == 0);
        sel = $urandom_range(0, 7);
        case (sel)
            0: v.waddr = 5'd8;  1: v.waddr = 5'd9;  2: v.waddr = 5'd11; 3: v.waddr = 5'd12;
            4: v.waddr = 5'd13; 5: v.waddr = 5'd14; 6: v.waddr = 5'd15;
            default: v.waddr = 5'($urandom);
        endcase
        v.wdata = (v.waddr == 5'd9) ? m_compare - 32'($urandom_range(0, 6)) : 32'($urandom);
        return v;
    endfunction

    task automatic apply(in_t v);
        stallM = v.stall; cp0writeM = v.wr; waddrM = v.waddr; wdataM = v.wdata;
        raddr = v.raddr; pcM = v.pc; in_delayslotM = v.ds; invalidM = v.inv;
        syscallM = v.sys; breakM = v.brk; eretM = v.eret; overflowM = v.ov;
        adel_fetchM = v.adelf; adel_dataM = v.adeld; ades_dataM = v.ades;
        bad_addrM = v.bad; int_i = v.intr;
    endtask

    // one cycle: drive, check combinational outputs mid-cycle, clock, advance the model
    task automatic run_cycle(in_t v);
        int win;
        logic ef;
        logic [31:0] en;
        apply(v);
        #4;
        win = m_winner(v);
        ef = !v.stall && (win >= 0 || v.eret);
        en = (win >= 0) ? VEC : m_epc;
        chk("flush", 32'(flush), 32'(ef));
        if (ef) chk("newpc", newpc, en);
        chk($sformatf("rdata[%0d]", v.raddr), rdata, m_read(v.raddr));
        chk("status_o", status_o, m_status);
        chk("cause_o", cause_o, m_cause());
        chk("epc_o", epc_o, m_epc);
        chk("timer_int", 32'(timer_int), 32'(m_ti));
        last_flush = flush; last_ti = timer_int; last_rdata = rdata;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    row_t tv [32];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rst_addr [4];
        logic [31:0] rst_exp  [4];
        logic seen;
        logic [31:0] t;

        tv[0]  = '{OP_WR, 32'hFFFF_0000, 32'h0, 1'b0, 1'b0, 5'd11, 5'd11, 1'b0, 32'h0, 32'h0};
        tv[1]  = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd11, 1'b0, 32'h0, 32'hFFFF_0000};
        tv[2]  = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0};
        tv[3]  = '{OP_INV, 32'h0, 32'hBFC0_0100, 1'b0, 1'b0, 5'd0, 5'd14, 1'b1, VEC, 32'h0};
        tv[4]  = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd14, 1'b0, 32'h0, 32'hBFC0_0100};
        tv[5]  = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0000_0028};
        tv[6]  = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd12, 1'b0, 32'h0, 32'h0040_0002};
        tv[7]  = '{OP_ERET, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd12, 1'b1, 32'hBFC0_0100, 32'h0040_0002};
        tv[8]  = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd12, 1'b0, 32'h0, 32'h0040_0000};
        tv[9]  = '{OP_OV | OP_SYS | OP_WR, 32'h1234, 32'h8000_0010, 1'b1, 1'b0, 5'd14, 5'd14, 1'b1, VEC, 32'hBFC0_0100};
        tv[10] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd14, 1'b0, 32'h0, 32'h8000_000C};
        tv[11] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h8000_0030};
        tv[12] = '{OP_ADES, 32'h3, 32'h8000_0020, 1'b0, 1'b0, 5'd0, 5'd8, 1'b1, VEC, 32'h0};
        tv[13] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd8, 1'b0, 32'h0, 32'h3};
        tv[14] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0000_0014};
        tv[15] = '{OP_ERET, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd14, 1'b1, 32'h8000_000C, 32'h8000_000C};
        tv[16] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd12, 1'b0, 32'h0, 32'h0040_0000};
        tv[17] = '{OP_WR, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 5'd20, 5'd20, 1'b0, 32'h0, 32'h0};
        tv[18] = '{OP_BRK, 32'h0, 32'h100, 1'b0, 1'b1, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0000_0014};
        tv[19] = '{OP_BRK, 32'h0, 32'h100, 1'b0, 1'b0, 5'd0, 5'd12, 1'b1, VEC, 32'h0040_0000};
        tv[20] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0000_0024};
        tv[21] = '{OP_ADELF | OP_INV, 32'h0, 32'h101, 1'b0, 1'b0, 5'd0, 5'd12, 1'b1, VEC, 32'h0040_0002};
        tv[22] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd8, 1'b0, 32'h0, 32'h101};
        tv[23] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0000_0010};
        tv[24] = '{OP_ERET, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd14, 1'b1, 32'h100, 32'h100};
        tv[25] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd12, 1'b0, 32'h0, 32'h0040_0000};
        tv[26] = '{OP_WR, 32'h300, 32'h0, 1'b0, 1'b0, 5'd13, 5'd13, 1'b0, 32'h0, 32'h0000_0010};
        tv[27] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0000_0310};
        tv[28] = '{OP_WR, 32'h0, 32'h0, 1'b0, 1'b0, 5'd15, 5'd15, 1'b0, 32'h0, PRID};
        tv[29] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd15, 1'b0, 32'h0, PRID};
        tv[30] = '{OP_WR, 32'h0, 32'h0, 1'b0, 1'b0, 5'd13, 5'd13, 1'b0, 32'h0, 32'h0000_0310};
        tv[31] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13, 1'b0, 32'h0, 32'h0000_0010};

        rst = 1'b0;
        apply(idle_in(5'd0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_addr = '{5'd12, 5'd13, 5'd14, 5'd9};
        rst_exp  = '{32'h0040_0000, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            raddr = rst_addr[i];
            #1;
            chk($sformatf("reset_read[%0d]", rst_addr[i]), rdata, rst_exp[i]);
        end
        chk("reset_flush", 32'(flush), 32'd0);
        rst = 1'b1;

        repeat (10) run_cycle(idle_in(5'd9));
        run_cycle(idle_in(5'd9));
        chk("count_after_10_clocks", last_rdata, 32'd5);

        for (int i = 0; i < 32; i++) begin
            run_cycle(row_in(tv[i]));
            chk($sformatf("tbl%0d_flush", i), 32'(last_flush), 32'(tv[i].exp_flush));
            if (tv[i].exp_flush) chk($sformatf("tbl%0d_newpc", i), newpc, tv[i].exp_newpc);
            chk($sformatf("tbl%0d_rdata", i), last_rdata, tv[i].exp_rdata);
        end

        // timer interrupt: enable IM7 + IE, arm Compare=3 from Count=0
        run_cycle(wr_in(5'd12, 32'h0000_8001, 5'd12));
        run_cycle(wr_in(5'd9, 32'h0, 5'd9));
        run_cycle(wr_in(5'd11, 32'd3, 5'd11));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            run_cycle(idle_in(5'd13));
            seen = last_flush;
        end
        chk("timer_irq_flush_seen", 32'(seen), 32'd1);
        run_cycle(idle_in(5'd13));
        t = last_rdata;
        chk("timer_irq_exccode", 32'(t[6:2]), 32'd0);
        chk("timer_ti_set", 32'(last_ti), 32'd1);
        run_cycle(wr_in(5'd11, 32'hFFFF_0000, 5'd13));
        run_cycle(idle_in(5'd13));
        chk("timer_ti_cleared", 32'(last_ti), 32'd0);
        run_cycle(wr_in(5'd12, 32'h0, 5'd12));

        // asynchronous reset in the middle of a faulting cycle
        begin
            in_t v = idle_in(5'd12);
            v.inv = 1; v.pc = 32'h200;
            apply(v);
            #2;
            chk("pre_reset_flush", 32'(flush), 32'd1);
            rst = 1'b0;
            #1;
            chk("reset_drops_flush", 32'(flush), 32'd0);
            chk("midreset_status", rdata, 32'h0040_0000);
            raddr = 5'd14; #1; chk("midreset_epc", rdata, 32'h0);
            raddr = 5'd13; #1; chk("midreset_cause", rdata, 32'h0);
            raddr = 5'd11; #1; chk("midreset_compare", rdata, 32'h0);
            apply(idle_in(5'd9));
            rst = 1'b1;
            model_reset();
            @(posedge clk);
            model_step(idle_in(5'd9));
            #1;
        end

        for (int i = 0; i < 400; i++) run_cycle(rand_in());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
